// File: rtl/serial_arith_pkg.sv
// Shared types and defaults for the bit-serial arithmetic path.
package serial_arith_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_fullsubtractor.sv
// Single-bit full subtractor: D = A - B - Bin with borrow out.
module fullsubtractor (
   input  logic A,
   input  logic B,
   input  logic Bin,
   output logic D,
   output logic Bout
);

   assign D    = A ^ B ^ Bin;
   assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b), LSB-first, one bit per clock.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   state_t           state_nx;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] r_sh;
   logic             borrow;
   logic             cell_d;
   logic             cell_bout;
   logic             load;
   logic             last;
   logic [WIDTH-1:0] r_final;
`ifdef SERIAL_SUB_OVF_EN
   logic             a_msb;
   logic             b_msb;
`endif

   fullsubtractor u_cell (
      .A    (a_sh[0]),
      .B    (b_sh[0]),
      .Bin  (borrow),
      .D    (cell_d),
      .Bout (cell_bout)
   );

   assign last    = (state == S_RUN) && (count == LAST);
   assign r_final = {cell_d, r_sh[WIDTH-1:1]};
   assign busy    = (state == S_RUN);
   assign done    = (state == S_DONE);

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               load     = 1'b1;
               state_nx = S_RUN;
            end
         end
         S_RUN: begin
            if (count == LAST) state_nx = S_DONE;
         end
         S_DONE: begin
            if (start) begin
               load     = 1'b1;
               state_nx = S_RUN;
            end else begin
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         count      <= '0;
         borrow     <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf        <= 1'b0;
`endif
      end else begin
         state <= state_nx;
         if (load) begin
            count  <= '0;
            borrow <= 1'b0;
         end else if (state == S_RUN) begin
            borrow <= cell_bout;
            if (!last) count <= count + CW'(1);
         end
         if (last) begin
            diff       <= r_final;
            borrow_out <= cell_bout;
`ifdef SERIAL_SUB_OVF_EN
            ovf        <= (a_msb ^ b_msb) & (a_msb ^ cell_d);
`endif
         end
      end
   end

   // Datapath shifters carry no reset: every bit is reloaded or overwritten before use.
   always_ff @(posedge clk) begin
      if (load) begin
         a_sh  <= a;
         b_sh  <= b;
`ifdef SERIAL_SUB_OVF_EN
         a_msb <= a[WIDTH-1];
         b_msb <= b[WIDTH-1];
`endif
      end else if (state == S_RUN) begin
         a_sh <= a_sh >> 1;
         b_sh <= b_sh >> 1;
         r_sh <= r_final;
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor against a timing/arithmetic model.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic       busy;
   logic       done;
   logic [7:0] diff;
   logic       borrow_out;
`ifdef SERIAL_SUB_OVF_EN
   logic       ovf;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   serial_subtractor #(.WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf        (ovf)
`endif
   );

   always #5 clk = ~clk;

   // Model: an accepted start at edge e gives busy after edges e..e+7, done after e+8.
   int         edge_n = 0;
   int         last_acc = 0;
   bit         have_op = 1'b0;
   logic [7:0] pa, pb;
   logic [7:0] m_diff = '0;
   logic       m_borrow = 1'b0;
   logic       m_ovf = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         have_op  = 1'b0;
         m_diff   = '0;
         m_borrow = 1'b0;
         m_ovf    = 1'b0;
      end else begin
         edge_n++;
         if (have_op && edge_n == last_acc + 8) begin
            m_diff   = pa - pb;
            m_borrow = (pa < pb);
            m_ovf    = (pa[7] ^ pb[7]) & (pa[7] ^ m_diff[7]);
         end
         if (start && !(have_op && edge_n <= last_acc + 8)) begin
            have_op  = 1'b1;
            last_acc = edge_n;
            pa       = a;
            pb       = b;
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", 32'(busy), 32'(have_op && edge_n >= last_acc && edge_n <= last_acc + 7));
         check("done", 32'(done), 32'(have_op && edge_n == last_acc + 8));
         check("diff", 32'(diff), 32'(m_diff));
         check("borrow_out", 32'(borrow_out), 32'(m_borrow));
`ifdef SERIAL_SUB_OVF_EN
         check("ovf", 32'(ovf), 32'(m_ovf));
`endif
      end
   end

   task automatic run_op(input logic [7:0] x, input logic [7:0] y, input string nm,
                         input logic [7:0] ed, input logic eb);
      int lat;
      @(negedge clk);
      a = x; b = y; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check({nm, "_latency"}, 32'(lat), 32'd9);
      check({nm, "_diff"}, 32'(diff), 32'(ed));
      check({nm, "_borrow"}, 32'(borrow_out), 32'(eb));
      check({nm, "_model_diff"}, 32'(m_diff), 32'(ed));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int ndone, first, second, i;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_diff", 32'(diff), 32'd0);
      check("reset_borrow", 32'(borrow_out), 32'd0);
      rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);

      run_op(8'd100, 8'd37, "t1", 8'd63, 1'b0);
      run_op(8'd5, 8'd10, "t2", 8'hFB, 1'b1);
      run_op(8'd255, 8'd255, "t3a", 8'd0, 1'b0);
      run_op(8'd0, 8'd1, "t3b", 8'd255, 1'b1);
`ifdef SERIAL_SUB_OVF_EN
      run_op(8'h80, 8'h01, "t6a", 8'h7F, 1'b0);
      check("t6a_ovf", 32'(ovf), 32'd1);
      run_op(8'h10, 8'h01, "t6b", 8'h0F, 1'b0);
      check("t6b_ovf", 32'(ovf), 32'd0);
`endif

      // Start pulse mid-run with other operands must be ignored.
      @(negedge clk);
      a = 8'd100; b = 8'd37; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      a = 8'h11; b = 8'h22; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ndone = 0;
      for (int k = 0; k < 15; k++) begin
         if (done) begin
            ndone++;
            check("t4_diff", 32'(diff), 32'd63);
         end
         @(negedge clk);
      end
      check("t4_pulses", 32'(ndone), 32'd1);

      // Reset in the middle of a run.
      @(negedge clk);
      a = 8'd9; b = 8'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_done", 32'(done), 32'd0);
      check("t5_diff", 32'(diff), 32'd0);
      check("t5_borrow", 32'(borrow_out), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("t5_no_done", 32'(ndone), 32'd0);
      run_op(8'd20, 8'd7, "t5_after", 8'd13, 1'b0);

      // Back-to-back: start held high through DONE.
      @(negedge clk);
      a = 8'd50; b = 8'd60; start = 1'b1;
      first = -1; second = -1; i = 0;
      while (second < 0 && i < 40) begin
         @(negedge clk);
         i++;
         if (first >= 0 && i == first + 1) start = 1'b0;
         if (done) begin
            if (first < 0) first = i;
            else second = i;
         end
      end
      start = 1'b0;
      check("b2b_first", 32'(first), 32'd9);
      check("b2b_spacing", 32'(second - first), 32'd9);

      // Randomized traffic; the compare process checks every cycle.
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         start = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 5))
            0: begin a = 8'h00; b = 8'($urandom); end
            1: begin a = 8'($urandom); b = 8'hFF; end
            default: begin a = 8'($urandom); b = 8'($urandom); end
         endcase
      end
      @(negedge clk);
      start = 1'b0;
      repeat (12) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
